// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage between the PC block and decode.
//
// Presents the current PC to a synchronous instruction memory (one-cycle read
// latency) and tracks the fetch in flight. Delivers the returned instruction,
// its PC and PC+INSTSIZE to decode. A hold register keeps the returned word
// while the pipeline is stalled, and a flush turns the next cycle into a bubble.
//
// Ports:
//   CLK          clock, all state updates on posedge
//   RESET        synchronous, active-high reset
//   PCIN         current PC from the PC block
//   STALL        hazard stall (the PC is frozen by the same signal)
//   FLUSH        squash the in-flight fetch; overrides STALL
//   IMEM_ADDR    word address to instruction memory (PCIN[IMEMADDRBITS-1:2])
//   IMEM_DATA    instruction memory read data, valid one cycle after address
//   INST_OUT     instruction to decode (NOP_INSTR for a bubble)
//   PC_OUT       PC of INST_OUT
//   PCINC_OUT    PC_OUT + INSTSIZE, wrapping
//   VALID_OUT    INST_OUT is a real instruction
//   ALIGN_ERR    PC_OUT is not word aligned while VALID_OUT
//   FETCH_COUNT  number of instructions handed to decode
module if_stage #(
  parameter int              DBITS        = 32,
  parameter int              IMEMADDRBITS = 16,
  parameter int              INSTSIZE     = 4,
  parameter logic [DBITS-1:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DBITS-1:0]        PCIN,
  input  logic                    STALL,
  input  logic                    FLUSH,
  output logic [IMEMADDRBITS-3:0] IMEM_ADDR,
  input  logic [DBITS-1:0]        IMEM_DATA,
  output logic [DBITS-1:0]        INST_OUT,
  output logic [DBITS-1:0]        PC_OUT,
  output logic [DBITS-1:0]        PCINC_OUT,
  output logic                    VALID_OUT,
  output logic                    ALIGN_ERR,
  output logic [31:0]             FETCH_COUNT
);

  // Fetch issued on the previous edge.
  logic [DBITS-1:0] f1_pc_r;
  logic             f1_valid_r;
  logic             f1_align_r;

  // Instruction captured on the first stalled edge, so it survives the memory
  // moving on to the next (frozen) PC.
  logic [DBITS-1:0] hold_inst_r;
  logic             hold_valid_r;

  logic [31:0]      cnt_r;

  logic             deliver_s;

  // Memory is indexed by word; the low two byte-address bits are dropped,
  // so misaligned PCs fetch the enclosing word.
  assign IMEM_ADDR = PCIN[IMEMADDRBITS-1:2];

  // Output selection: bubble, then held word, then live memory data.
  always_comb begin
    INST_OUT = NOP_INSTR;
    if (!f1_valid_r) begin
      INST_OUT = NOP_INSTR;
    end else if (hold_valid_r) begin
      INST_OUT = hold_inst_r;
    end else begin
      INST_OUT = IMEM_DATA;
    end
  end

  assign PC_OUT      = f1_pc_r;
  assign PCINC_OUT   = f1_pc_r + DBITS'(INSTSIZE);
  assign VALID_OUT   = f1_valid_r;
  assign ALIGN_ERR   = f1_valid_r & f1_align_r;
  assign FETCH_COUNT = cnt_r;

  // Decode consumes the current instruction only when the pipe advances.
  assign deliver_s = f1_valid_r & ~STALL & ~FLUSH;

  // Fetch tracking and hold register; RESET > FLUSH > STALL > advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      f1_pc_r      <= '0;
      f1_valid_r   <= 1'b0;
      f1_align_r   <= 1'b0;
      hold_inst_r  <= '0;
      hold_valid_r <= 1'b0;
    end else if (FLUSH) begin
      f1_pc_r      <= PCIN;
      f1_valid_r   <= 1'b0;
      f1_align_r   <= |PCIN[1:0];
      hold_valid_r <= 1'b0;
    end else if (STALL) begin
      if (!hold_valid_r) begin
        hold_inst_r  <= IMEM_DATA;
        hold_valid_r <= 1'b1;
      end else begin
        hold_inst_r  <= hold_inst_r;
        hold_valid_r <= hold_valid_r;
      end
    end else begin
      f1_pc_r      <= PCIN;
      f1_valid_r   <= 1'b1;
      f1_align_r   <= |PCIN[1:0];
      hold_valid_r <= 1'b0;
    end
  end

  // Count of instructions handed to decode; wraps naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= 32'd0;
    end else if (deliver_s) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. The bench acts as the PC block (directed
// PCIN per cycle) and as a one-cycle-latency instruction memory whose word at
// word address wa is {16'hCAFE, 2'b00, wa}. A behavioural model tracks which
// PC decode should be looking at; the expected instruction is simply the
// memory word at that PC, so the DUT's hold logic is checked, not copied.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic [31:0] PCIN, IMEM_DATA;
  logic [13:0] IMEM_ADDR;
  logic [31:0] INST_OUT, PC_OUT, PCINC_OUT, FETCH_COUNT;
  logic        VALID_OUT, ALIGN_ERR;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } pin_t;
  pin_t pins[$];

  always #5 CLK = ~CLK;

  if_stage dut (
    .CLK(CLK), .RESET(RESET), .PCIN(PCIN), .STALL(STALL), .FLUSH(FLUSH),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA), .INST_OUT(INST_OUT),
    .PC_OUT(PC_OUT), .PCINC_OUT(PCINC_OUT), .VALID_OUT(VALID_OUT),
    .ALIGN_ERR(ALIGN_ERR), .FETCH_COUNT(FETCH_COUNT)
  );

  function automatic logic [31:0] memw(input logic [13:0] wa);
    return {16'hCAFE, 2'b00, wa};
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge CLK) IMEM_DATA <= memw(IMEM_ADDR);

  // Behavioural model: which PC decode sees, whether it is real, and the count.
  logic        m_known = 1'b0;
  logic        m_valid;
  logic [31:0] m_pc, m_cnt;

  always @(posedge CLK) begin
    if (RESET) begin
      m_known <= 1'b1;
      m_valid <= 1'b0;
      m_pc    <= 32'd0;
      m_cnt   <= 32'd0;
    end else begin
      if (m_valid && !STALL && !FLUSH) m_cnt <= m_cnt + 32'd1;
      if (FLUSH) begin
        m_valid <= 1'b0;
        m_pc    <= PCIN;
      end else if (!STALL) begin
        m_valid <= 1'b1;
        m_pc    <= PCIN;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return INST_OUT;
      1: return PC_OUT;
      2: return PCINC_OUT;
      3: return {31'd0, VALID_OUT};
      4: return {31'd0, ALIGN_ERR};
      default: return FETCH_COUNT;
    endcase
  endfunction

  // Compare process: model check every cycle, then any hand-pinned literals.
  always @(negedge CLK) begin
    if (m_known) begin
      cmp("inst",  INST_OUT,  m_valid ? memw(m_pc[15:2]) : NOP);
      cmp("pc",    PC_OUT,    m_pc);
      cmp("pcinc", PCINC_OUT, m_pc + 32'd4);
      cmp("valid", {31'd0, VALID_OUT}, {31'd0, m_valid});
      cmp("align", {31'd0, ALIGN_ERR}, {31'd0, m_valid & (|m_pc[1:0])});
      cmp("count", FETCH_COUNT, m_cnt);
      cmp("imem_addr", {18'd0, IMEM_ADDR}, {18'd0, PCIN[15:2]});
    end
    while (pins.size() > 0) begin
      pin_t p;
      p = pins.pop_front();
      cmp(p.name, pick(p.sel), p.exp);
    end
  end

  task automatic step(input logic [31:0] pc, input logic st, input logic fl, input logic rs);
    PCIN  = pc;
    STALL = st;
    FLUSH = fl;
    RESET = rs;
    @(posedge CLK);
    #1;
  endtask

  task automatic pin(input string n, input int s, input logic [31:0] e);
    pins.push_back('{n, s, e});
  endtask

  // Pin decode-visible state: instruction, PC, valid, count.
  task automatic pin4(input string n, input logic [31:0] inst, input logic [31:0] pc,
                      input logic v, input logic [31:0] fc);
    pin({n, "_inst"}, 0, inst);
    pin({n, "_pc"}, 1, pc);
    pin({n, "_valid"}, 3, {31'd0, v});
    pin({n, "_count"}, 5, fc);
  endtask

  initial begin
    PCIN = 32'h60; STALL = 1'b0; FLUSH = 1'b0; RESET = 1'b1;
    step(32'h60, 1'b0, 1'b0, 1'b1);
    step(32'h60, 1'b0, 1'b0, 1'b1);
    pin4("reset", NOP, 32'h0, 1'b0, 32'd0);
    pin("reset_pcinc", 2, 32'h4);
    pin("reset_align", 4, 32'd0);

    // Sequential run from 0x60.
    step(32'h60, 1'b0, 1'b0, 1'b0);
    pin4("seq60", 32'hCAFE_0018, 32'h60, 1'b1, 32'd0);
    pin("seq60_pcinc", 2, 32'h64);
    step(32'h64, 1'b0, 1'b0, 1'b0);
    pin4("seq64", 32'hCAFE_0019, 32'h64, 1'b1, 32'd1);

    // Three-cycle stall on 0x64; PC frozen at 0x68.
    for (int i = 0; i < 3; i++) begin
      step(32'h68, 1'b1, 1'b0, 1'b0);
      pin4("stall", 32'hCAFE_0019, 32'h64, 1'b1, 32'd1);
    end
    step(32'h68, 1'b0, 1'b0, 1'b0);
    pin4("release", 32'hCAFE_001A, 32'h68, 1'b1, 32'd2);
    step(32'h6C, 1'b0, 1'b0, 1'b0);
    pin4("seq6c", 32'hCAFE_001B, 32'h6C, 1'b1, 32'd3);

    // Flush redirect to 0x200.
    step(32'h200, 1'b0, 1'b1, 1'b0);
    pin4("flush", NOP, 32'h200, 1'b0, 32'd3);
    step(32'h200, 1'b0, 1'b0, 1'b0);
    pin4("redir200", 32'hCAFE_0080, 32'h200, 1'b1, 32'd3);
    step(32'h204, 1'b0, 1'b0, 1'b0);
    pin4("seq204", 32'hCAFE_0081, 32'h204, 1'b1, 32'd4);

    // Stall with an active hold, then STALL+FLUSH together.
    step(32'h208, 1'b1, 1'b0, 1'b0);
    step(32'h208, 1'b1, 1'b0, 1'b0);
    pin4("hold204", 32'hCAFE_0081, 32'h204, 1'b1, 32'd4);
    step(32'h300, 1'b1, 1'b1, 1'b0);
    pin4("stflush", NOP, 32'h300, 1'b0, 32'd4);
    step(32'h300, 1'b0, 1'b0, 1'b0);
    pin4("redir300", 32'hCAFE_00C0, 32'h300, 1'b1, 32'd4);
    step(32'h304, 1'b0, 1'b0, 1'b0);
    pin4("seq304", 32'hCAFE_00C1, 32'h304, 1'b1, 32'd5);

    // Misaligned PC.
    step(32'h62, 1'b0, 1'b0, 1'b0);
    pin4("mis62", 32'hCAFE_0018, 32'h62, 1'b1, 32'd6);
    pin("mis62_align", 4, 32'd1);
    pin("mis62_pcinc", 2, 32'h66);
    step(32'h70, 1'b0, 1'b0, 1'b0);
    pin("al70_align", 4, 32'd0);

    // PC wrap.
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    pin("wrap_pc", 1, 32'hFFFF_FFFC);
    pin("wrap_pcinc", 2, 32'h0);
    pin("wrap_inst", 0, 32'hCAFE_3FFF);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    pin("wrap0_pc", 1, 32'h0);

    // Reset during a stall.
    step(32'h10, 1'b0, 1'b0, 1'b0);
    step(32'h14, 1'b1, 1'b0, 1'b0);
    step(32'h14, 1'b1, 1'b0, 1'b0);
    pin4("stall10", 32'hCAFE_0004, 32'h10, 1'b1, 32'd10);
    step(32'h14, 1'b1, 1'b0, 1'b1);
    pin4("rststall", NOP, 32'h0, 1'b0, 32'd0);
    pin("rststall_pcinc", 2, 32'h4);
    pin("rststall_align", 4, 32'd0);
    step(32'h20, 1'b0, 1'b0, 1'b0);
    pin4("after_rst", 32'hCAFE_0008, 32'h20, 1'b1, 32'd0);
    step(32'h24, 1'b0, 1'b0, 1'b0);
    pin("after_rst_count", 5, 32'd1);

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
